ones_frame_accum: RTL and testbench
===================================

// Module: ones_frame_accum
// PURPOSE
//  Downstream of the per-word popcount stage. Consumes one registered ones-count per accepted beat.
//  Sums the counts over a frame delimited by in_last, or by a word-count cap.
//  Presents the frame total, word count and status flags on a valid/ready output port.
//  Holds the result until a sink such as a density monitor or CSR readback accepts it.
// PARAMETERS
//  DATA_WIDTH  32   width of the word counted upstream; in_ones is $clog2(DATA_WIDTH)+1 bits
//  MAX_WORDS   256  frame length cap in beats; 2..65535
//  TOTAL_W     16   accumulator / out_total width
// PORTS
//  clk        in   1                     rising-edge clock, the only clock
//  rst        in   1                     synchronous, active-high reset
//  in_valid   in   1                     in_ones / in_last are valid this cycle
//  in_ready   out  1                     block accepts a beat this cycle
//  in_ones    in   $clog2(DATA_WIDTH)+1  ones count of one word
//  in_last    in   1                     final beat of the frame
//  out_valid  out  1                     frame result is presented
//  out_ready  in   1                     sink accepts the result
//  out_total  out  TOTAL_W               sum of in_ones over the frame, saturating
//  out_words  out  $clog2(MAX_WORDS)+1   beats in the frame, 1..MAX_WORDS
//  out_sat    out  1                     out_total saturated at 2**TOTAL_W-1
//  out_trunc  out  1                     frame was closed by the MAX_WORDS cap, not by in_last
// BEHAVIOUR
//  - Reset (rst=1 at a clk edge): state=ACCUM; accumulator, word count and flags = 0; out_valid=0.
//    All out_* data outputs = 0.
//  - Reset mid-frame or mid-HOLD discards the partial frame or the pending result; nothing is emitted.
//  - FSM ACCUM: in_ready=1, out_valid=0. A beat is accepted when in_valid&in_ready.
//  - Accepted beat: acc <= sat(acc + clamp(in_ones)); words <= words+1.
//  - clamp(): an in_ones value above DATA_WIDTH is treated as DATA_WIDTH. Upstream never produces one.
//  - sat(): if the true sum is >= 2**TOTAL_W, acc = 2**TOTAL_W-1 and the sticky sat flag is set.
//  - Frame end on an accepted beat: in_last=1, or words+1==MAX_WORDS.
//    The beat's contribution is included in the result.
//    trunc = (words+1==MAX_WORDS) & ~in_last.
//  - At frame end, register out_total/out_words/out_sat/out_trunc and go to HOLD.
//    out_valid=1 the cycle after the last beat is accepted (latency 1).
//    acc/words/sat clear in the same edge.
//  - HOLD: in_ready=0; outputs stable until out_valid&out_ready.
//    The accepting edge returns to ACCUM; in_ready=1 on the next cycle. There is no same-cycle bypass.
//    Throughput is therefore one frame per (beats+1) cycles minimum.
//  - out_ready is ignored while out_valid=0. in_valid during HOLD is ignored; the upstream must hold its beat.
//  - Single-beat frame (in_last on the first beat): out_words=1, out_total=clamp(in_ones).
//  - in_last on the MAX_WORDS-th beat: out_trunc=0.
//  - Widths: internal sum is TOTAL_W+1 bits, compared against the saturation limit.
//    out_words counts to MAX_WORDS without wrapping.
// STRUCTURE
//  - Package countbits_pkg holds:
//    - the FSM state enum {ACCUM, HOLD};
//    - ONES_W(DATA_WIDTH) = $clog2(DATA_WIDTH)+1;
//    - the words-width function.
//  - Sub-module sat_add: combinational TOTAL_W saturating adder with an overflow output.
//    It is reused by later accumulation stages.
//  - Everything else is a single always block plus the output registers.
// TESTING
//  1. 4 beats ones={32,0,17,5}, last on beat 4, out_ready=1
//     -> one cycle after beat 4, out_valid=1, total=54, words=4, sat=0, trunc=0.
//  2. MAX_WORDS=8, 10 beats of ones=3, no in_last
//     -> first result total=24, words=8, trunc=1.
//     -> remaining 2 beats stay pending until a last or the cap.
//  3. TOTAL_W=8, 10 beats ones=32 with last
//     -> total=255, sat=1, words=10; the next frame starts with sat cleared.
//  4. Result pending with out_ready=0 for 5 cycles while in_valid=1
//     -> in_ready=0 and outputs stable throughout.
//     -> on out_ready=1, the next beat is accepted one cycle after the handshake.
//  5. rst=1 after 3 beats, then a 1-beat frame ones=7 last
//     -> no result for the aborted frame; next result total=7, words=1.
//  6. Random valid/ready back-pressure, 1000 frames; a scoreboard compares against a reference sum model
//     -> zero mismatches, no lost or duplicated frames.

Source files
------------

// File: rtl/countbits_pkg.sv
// Shared types and width helpers for the bit-counting datapath stages.
package countbits_pkg;

  typedef enum logic {ACCUM, HOLD} state_t;

  function automatic int ONES_W(input int dataWidth);
    return $clog2(dataWidth) + 1;
  endfunction

  // Wide enough to hold the cap value itself, not just cap-1.
  function automatic int WORDS_W(input int maxWords);
    return $clog2(maxWords) + 1;
  endfunction

endpackage

// File: rtl/ones_frame_accum_sat_add.sv
// Combinational unsigned adder that clips at all-ones and flags the overflow.
module sat_add #(
  parameter int W = 16
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] sum_o,
  output logic         ovf_o
);

  logic [W:0] wideSum;

  // The carry bit is exactly the "true sum >= 2**W" condition.
  assign wideSum = {1'b0, a_i} + {1'b0, b_i};
  assign ovf_o   = wideSum[W];
  assign sum_o   = wideSum[W] ? {W{1'b1}} : wideSum[W-1:0];

endmodule

// File: rtl/ones_frame_accum.sv
// Sums per-word ones counts over a frame and holds the frame result on a
// valid/ready port until the sink takes it.
module ones_frame_accum
  import countbits_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int MAX_WORDS  = 256,
  parameter int TOTAL_W    = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [ONES_W(DATA_WIDTH)-1:0]    in_ones,
  input  logic                             in_last,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [TOTAL_W-1:0]               out_total,
  output logic [WORDS_W(MAX_WORDS)-1:0]    out_words,
  output logic                             out_sat,
  output logic                             out_trunc
);

  localparam int OW = ONES_W(DATA_WIDTH);
  localparam int WW = WORDS_W(MAX_WORDS);

  state_t             state_q;
  logic [TOTAL_W-1:0] acc_q;
  logic [TOTAL_W-1:0] acc_d;
  logic [WW-1:0]      words_q;
  logic [WW-1:0]      words_d;
  logic               sat_q;
  logic               sat_d;
  logic               addOvf;
  logic [OW-1:0]      clampedOnes;
  logic               capHit;
  logic               frameEnd;

  logic [TOTAL_W-1:0] outTotal_q;
  logic [WW-1:0]      outWords_q;
  logic               outSat_q;
  logic               outTrunc_q;

  // Out-of-range counts never come from upstream, but must not corrupt the sum.
  assign clampedOnes = (in_ones > OW'(DATA_WIDTH)) ? OW'(DATA_WIDTH) : in_ones;

  sat_add #(.W(TOTAL_W)) uSatAdd (
    .a_i   (acc_q),
    .b_i   (TOTAL_W'(clampedOnes)),
    .sum_o (acc_d),
    .ovf_o (addOvf)
  );

  assign sat_d    = sat_q | addOvf;
  assign words_d  = words_q + WW'(1);
  assign capHit   = (words_d == WW'(MAX_WORDS));
  assign frameEnd = in_last | capHit;

  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == HOLD);
  assign out_total = outTotal_q;
  assign out_words = outWords_q;
  assign out_sat   = outSat_q;
  assign out_trunc = outTrunc_q;

  // Closing a frame snapshots the running sum into the output registers and
  // clears the accumulator in the same edge so the next frame starts clean.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ACCUM;
      acc_q      <= '0;
      words_q    <= '0;
      sat_q      <= 1'b0;
      outTotal_q <= '0;
      outWords_q <= '0;
      outSat_q   <= 1'b0;
      outTrunc_q <= 1'b0;
    end else begin
      case (state_q)
        ACCUM: begin
          if (in_valid) begin
            if (frameEnd) begin
              outTotal_q <= acc_d;
              outWords_q <= words_d;
              outSat_q   <= sat_d;
              outTrunc_q <= capHit & ~in_last;
              acc_q      <= '0;
              words_q    <= '0;
              sat_q      <= 1'b0;
              state_q    <= HOLD;
            end else begin
              acc_q   <= acc_d;
              words_q <= words_d;
              sat_q   <= sat_d;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            state_q <= ACCUM;
          end
        end
        default: state_q <= ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_ones_frame_accum.sv
// Directed and randomised checks of ones_frame_accum against a frame-sum model.
module tb_ones_frame_accum;

  localparam int DW    = 32;
  localparam int MAXW  = 12;
  localparam int TW    = 8;
  localparam int LIMIT = (1 << TW) - 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [5:0] in_ones = '0;
  logic       in_last = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_total;
  logic [4:0] out_words;
  logic       out_sat;
  logic       out_trunc;

  int  nChecks = 0;
  int  nFails  = 0;
  bit  randMode = 1'b0;
  bit  modelLive = 1'b0;

  int  frameBeats[$];
  bit  expValid = 1'b0;
  int  expTotal, expWords, beatSum;
  bit  expSat, expTrunc;
  int  framesModel = 0;
  int  framesDut = 0;

  ones_frame_accum #(.DATA_WIDTH(DW), .MAX_WORDS(MAXW), .TOTAL_W(TW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ones   (in_ones),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_total (out_total),
    .out_words (out_words),
    .out_sat   (out_sat),
    .out_trunc (out_trunc)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string name, input int act, input int exp);
    nChecks++;
    if (act != exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Frame-level model: a result is pending until taken, and only while none is
  // pending can a beat enter the current frame; a frame closes on last or cap.
  always @(posedge clk) begin
    if (rst) begin
      frameBeats.delete();
      expValid  = 1'b0;
      modelLive = 1'b1;
    end else if (modelLive) begin
      if (out_valid && out_ready) framesDut++;
      if (expValid) begin
        if (out_ready) expValid = 1'b0;
      end else if (in_valid) begin
        frameBeats.push_back((int'(in_ones) > DW) ? DW : int'(in_ones));
        if (in_last || frameBeats.size() == MAXW) begin
          beatSum = 0;
          foreach (frameBeats[i]) beatSum += frameBeats[i];
          expTotal = (beatSum > LIMIT) ? LIMIT : beatSum;
          expSat   = (beatSum > LIMIT);
          expWords = frameBeats.size();
          expTrunc = !in_last;
          expValid = 1'b1;
          framesModel++;
          frameBeats.delete();
        end
      end
    end
  end

  always @(negedge clk) begin
    if (modelLive && !rst) begin
      cmp("in_ready", int'(in_ready), int'(!expValid));
      cmp("out_valid", int'(out_valid), int'(expValid));
      if (expValid) begin
        cmp("out_total", int'(out_total), expTotal);
        cmp("out_words", int'(out_words), expWords);
        cmp("out_sat", int'(out_sat), int'(expSat));
        cmp("out_trunc", int'(out_trunc), int'(expTrunc));
      end
    end
  end

  always @(negedge clk) begin
    if (randMode) out_ready = ($urandom_range(0, 3) != 0);
  end

  // Called at a negedge; returns at the negedge after the beat was taken.
  task automatic applyStimulus(input int ones, input bit last);
    int budget = 0;
    in_valid = 1'b1;
    in_ones  = 6'(ones);
    in_last  = last;
    while (!in_ready && budget < 200) begin
      @(negedge clk);
      budget++;
    end
    if (!in_ready) begin
      nChecks++;
      nFails++;
      $display("[TB] FAIL beat accept timeout: in_ready stayed %0d, expected 1", in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input int total, input int words,
                             input bit sat, input bit trunc);
    cmp({tag, " valid"}, int'(out_valid), 1);
    cmp({tag, " total"}, int'(out_total), total);
    cmp({tag, " words"}, int'(out_words), words);
    cmp({tag, " sat"},   int'(out_sat), int'(sat));
    cmp({tag, " trunc"}, int'(out_trunc), int'(trunc));
    cmp({tag, " model total"}, expTotal, total);
    cmp({tag, " model words"}, expWords, words);
  endtask

  task automatic drain();
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int len, dutBase, genFrames;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    cmp("reset in_ready", int'(in_ready), 1);
    cmp("reset out_valid", int'(out_valid), 0);
    cmp("reset out_total", int'(out_total), 0);
    cmp("reset out_words", int'(out_words), 0);
    cmp("reset flags", int'({out_sat, out_trunc}), 0);

    out_ready = 1'b1;
    applyStimulus(32, 0);
    applyStimulus(0, 0);
    applyStimulus(17, 0);
    applyStimulus(5, 1);
    checkOutput("t1", 54, 4, 0, 0);
    drain();

    for (int i = 0; i < 12; i++) applyStimulus(3, 0);
    checkOutput("t2 cap", 36, 12, 0, 1);
    applyStimulus(3, 0);
    applyStimulus(3, 0);
    repeat (3) @(negedge clk);
    cmp("t2 pending valid", int'(out_valid), 0);
    applyStimulus(3, 1);
    checkOutput("t2 tail", 9, 3, 0, 0);
    drain();

    for (int i = 0; i < 10; i++) applyStimulus(32, i == 9);
    checkOutput("t3 sat", 255, 10, 1, 0);
    drain();
    applyStimulus(4, 1);
    checkOutput("t3 next", 4, 1, 0, 0);
    drain();

    for (int i = 0; i < 12; i++) applyStimulus(1, i == 11);
    checkOutput("last at cap", 12, 12, 0, 0);
    drain();
    applyStimulus(63, 1);
    checkOutput("clamp", 32, 1, 0, 0);
    drain();

    out_ready = 1'b0;
    applyStimulus(5, 0);
    applyStimulus(6, 1);
    in_valid = 1'b1;
    in_ones  = 6'd9;
    in_last  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cmp("t4 in_ready held", int'(in_ready), 0);
      checkOutput("t4 hold", 11, 2, 0, 0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    cmp("t4 in_ready after take", int'(in_ready), 1);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    checkOutput("t4 next", 9, 1, 0, 0);
    drain();

    applyStimulus(1, 0);
    applyStimulus(2, 0);
    applyStimulus(3, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    cmp("t5 no result", int'(out_valid), 0);
    applyStimulus(7, 1);
    checkOutput("t5", 7, 1, 0, 0);
    drain();

    dutBase   = framesDut;
    genFrames = 0;
    randMode  = 1'b1;
    for (int f = 0; f < 1000; f++) begin
      len = $urandom_range(1, 14);
      genFrames += (len > MAXW) ? 2 : 1;
      for (int b = 0; b < len; b++) begin
        repeat ($urandom_range(0, 2)) @(negedge clk);
        applyStimulus($urandom_range(0, 40), b == len - 1);
      end
    end
    randMode = 1'b0;
    drain();
    repeat (3) @(negedge clk);
    cmp("random frame count", framesDut - dutBase, genFrames);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nChecks, nFails);
    $finish;
  end

endmodule
